// File: rtl/rob_ooo_tagged_if.sv
// Host and memory handshake bundle for the tagged reorder buffer.
// Signal suffixes are named from the reorder buffer's point of view.
interface rob_ooo_tagged_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              host_req_valid_i;
    logic              host_req_ready_o;
    logic [ADDR_W-1:0] host_req_addr_i;
    logic              host_req_we_i;
    logic [DATA_W-1:0] host_req_wdata_i;
    logic              host_rsp_valid_o;
    logic              host_rsp_ready_i;
    logic [DATA_W-1:0] host_rsp_rdata_o;
    logic              host_rsp_err_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_req_we_o;
    logic [DATA_W-1:0] mem_req_wdata_o;
    logic [TAG_W-1:0]  mem_req_tag_o;
    logic              mem_rsp_valid_i;
    logic              mem_rsp_ready_o;
    logic [TAG_W-1:0]  mem_rsp_tag_i;
    logic [DATA_W-1:0] mem_rsp_rdata_i;
    logic              mem_rsp_err_i;

    modport slave (
        input  host_req_valid_i, host_req_addr_i, host_req_we_i, host_req_wdata_i,
        output host_req_ready_o,
        output host_rsp_valid_o, host_rsp_rdata_o, host_rsp_err_o,
        input  host_rsp_ready_i,
        output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tag_o,
        input  mem_req_ready_i,
        input  mem_rsp_valid_i, mem_rsp_tag_i, mem_rsp_rdata_i, mem_rsp_err_i,
        output mem_rsp_ready_o
    );

    modport master (
        output host_req_valid_i, host_req_addr_i, host_req_we_i, host_req_wdata_i,
        input  host_req_ready_o,
        input  host_rsp_valid_o, host_rsp_rdata_o, host_rsp_err_o,
        output host_rsp_ready_i,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tag_o,
        output mem_req_ready_i,
        output mem_rsp_valid_i, mem_rsp_tag_i, mem_rsp_rdata_i, mem_rsp_err_i,
        input  mem_rsp_ready_o
    );
endinterface

// File: rtl/rob_ooo_tagged.sv
// Tagged reorder buffer: memory responses complete cells in any order,
// host responses retire strictly in allocation order.
module rob_ooo_tagged #(
    parameter  int NUM_CELL = 16,
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    localparam int TAG_W    = $clog2(NUM_CELL)
) (
    input  logic             clk,
    input  logic             rstn,
    rob_ooo_tagged_if.slave  bus,
    input  logic [TAG_W:0]   limit_i,
    output logic [TAG_W:0]   occupancy_o,
    output logic             spurious_o
);
    localparam logic [1:0]     CELL_FREE = 2'd0;
    localparam logic [1:0]     CELL_PEND = 2'd1;
    localparam logic [1:0]     CELL_DONE = 2'd2;
    localparam logic [TAG_W:0] CELL_CNT  = (TAG_W+1)'(NUM_CELL);

    logic [1:0]        cellState_q [NUM_CELL];
    logic [1:0]        cellState_d [NUM_CELL];
    logic [DATA_W-1:0] cellData_q  [NUM_CELL];
    logic              cellErr_q   [NUM_CELL];
    logic [TAG_W-1:0]  allocPtr_q, allocPtr_d;
    logic [TAG_W-1:0]  retirePtr_q, retirePtr_d;
    logic [TAG_W:0]    occupancy_q, occupancy_d;
    logic              spurious_q, spurious_d;

    logic [TAG_W:0]    effLimit;
    logic              canAlloc;
    logic              allocFire;
    logic              rspAccept;
    logic              rspHit;
    logic              retireFire;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;

    // Slot availability depends on registered occupancy only, so a retire never opens a slot combinationally.
    assign effLimit  = (limit_i == '0 || limit_i > CELL_CNT) ? CELL_CNT : limit_i;
    assign canAlloc  = rstn && (occupancy_q < effLimit);

    assign reqAddr   = bus.host_req_addr_i;
    assign reqWdata  = bus.host_req_wdata_i;

    assign bus.host_req_ready_o = bus.mem_req_ready_i & canAlloc;
    assign bus.mem_req_valid_o  = bus.host_req_valid_i & canAlloc;
    assign bus.mem_req_addr_o   = reqAddr;
    assign bus.mem_req_we_o     = bus.host_req_we_i;
    assign bus.mem_req_wdata_o  = reqWdata;
    assign bus.mem_req_tag_o    = allocPtr_q;
    assign allocFire            = bus.host_req_valid_i & bus.host_req_ready_o;

    // A response only counts when its cell is PEND; a cell allocated in the same cycle is still FREE here.
    assign bus.mem_rsp_ready_o  = rstn;
    assign rspAccept            = bus.mem_rsp_valid_i & rstn;
    assign rspHit               = rspAccept && (cellState_q[bus.mem_rsp_tag_i] == CELL_PEND);

    assign bus.host_rsp_valid_o = rstn && (cellState_q[retirePtr_q] == CELL_DONE);
    assign bus.host_rsp_rdata_o = cellData_q[retirePtr_q];
    assign bus.host_rsp_err_o   = cellErr_q[retirePtr_q];
    assign retireFire           = bus.host_rsp_valid_o & bus.host_rsp_ready_i;

    assign occupancy_o = occupancy_q;
    assign spurious_o  = spurious_q;

    always_comb begin
        cellState_d = cellState_q;
        if (rspHit) begin
            cellState_d[bus.mem_rsp_tag_i] = CELL_DONE;
        end
        if (retireFire) begin
            cellState_d[retirePtr_q] = CELL_FREE;
        end
        if (allocFire) begin
            cellState_d[allocPtr_q] = CELL_PEND;
        end

        allocPtr_d  = allocFire  ? allocPtr_q + TAG_W'(1)  : allocPtr_q;
        retirePtr_d = retireFire ? retirePtr_q + TAG_W'(1) : retirePtr_q;

        occupancy_d = occupancy_q;
        case ({allocFire, retireFire})
            2'b10:   occupancy_d = occupancy_q + (TAG_W+1)'(1);
            2'b01:   occupancy_d = occupancy_q - (TAG_W+1)'(1);
            default: occupancy_d = occupancy_q;
        endcase

        spurious_d = rspAccept & ~rspHit;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cellState_q <= '{default: CELL_FREE};
            allocPtr_q  <= '0;
            retirePtr_q <= '0;
            occupancy_q <= '0;
            spurious_q  <= 1'b0;
        end else begin
            cellState_q <= cellState_d;
            allocPtr_q  <= allocPtr_d;
            retirePtr_q <= retirePtr_d;
            occupancy_q <= occupancy_d;
            spurious_q  <= spurious_d;
        end
    end

    // Payload storage needs no reset: it is only observed once its cell reaches DONE.
    always_ff @(posedge clk) begin
        if (rspHit) begin
            cellData_q[bus.mem_rsp_tag_i] <= bus.mem_rsp_rdata_i;
            cellErr_q[bus.mem_rsp_tag_i]  <= bus.mem_rsp_err_i;
        end
    end
endmodule
